// File: rtl/anchor_updater_pkg.sv
// Shared types and constants for the octree anchor updater: FSM states,
// slot geometry and the position-code-to-slot hash.
package updater_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_FEAT = 3'd1,
        WR_DIR  = 3'd2,
        RD_DIR  = 3'd3,
        CMP     = 3'd4,
        CLR_DIR = 3'd5,
        DONE    = 3'd6
    } state_e;

    localparam int FEAT_WORDS = 7;
    localparam int SLOT_WORDS = 8;
    localparam int SLOT_BITS  = 9;
    localparam int VALID_BIT  = 63;
    localparam int POS_W      = 14;

    // Upper position bits are folded onto slot bits [8:4].
    function automatic logic [SLOT_BITS-1:0] slot_hash(input logic [POS_W-1:0] pos);
        return pos[8:0] ^ {pos[13:9], 4'b0};
    endfunction

endpackage

// File: rtl/anchor_updater_feat_packer.sv
// Selects 64-bit word k of the latched feature vector, zero-padding the tail
// so the last word carries only the remaining feature bits.
module updater_feat_packer
    import updater_pkg::*;
#(
    parameter int FEATURE_WIDTH = 400,
    parameter int WORD_WIDTH    = 64
) (
    input  logic [FEATURE_WIDTH-1:0] feature,
    input  logic [2:0]               k,
    output logic [WORD_WIDTH-1:0]    word
);

    localparam int PAD_WIDTH = SLOT_WORDS * WORD_WIDTH;

    logic [PAD_WIDTH-1:0] padded;

    always_comb begin
        padded                     = '0;
        padded[FEATURE_WIDTH-1:0]  = feature;
        word                       = padded[k*WORD_WIDTH +: WORD_WIDTH];
    end

endmodule

// File: rtl/anchor_updater.sv
// Octree anchor insert/delete engine driving a directory SRAM and a feature SRAM.
// Optional macro UPDATER_COLLISION_CHECK_EN: add refuses to evict a different valid tag.
module anchor_updater
    import updater_pkg::*;
#(
    parameter int FEATURE_WIDTH    = 400,
    parameter int ENCODE_WIDTH     = 12,
    parameter int LEVEL_WIDTH      = 2,
    parameter int SRAM1_ADDR_WIDTH = 12,
    parameter int SRAM1_DATA_WIDTH = 64,
    parameter int SRAM2_ADDR_WIDTH = 12,
    parameter int SRAM2_DATA_WIDTH = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 add_anchor,
    input  logic                                 del_anchor,
    output logic                                 add_done,
    output logic                                 del_done,
`ifdef UPDATER_COLLISION_CHECK_EN
    output logic                                 add_collision,
`endif
    input  logic [LEVEL_WIDTH+ENCODE_WIDTH-1:0]  pos_encode,
    input  logic [FEATURE_WIDTH-1:0]             feature_in,
    output logic                                 sram_1_CEN,
    output logic [SRAM1_ADDR_WIDTH-1:0]          sram_1_A,
    output logic [SRAM1_DATA_WIDTH-1:0]          sram_1_D,
    output logic                                 sram_1_GWEN,
    input  logic [SRAM1_DATA_WIDTH-1:0]          sram_1_Q,
    output logic                                 sram_2_CEN,
    output logic [SRAM2_ADDR_WIDTH-1:0]          sram_2_A,
    output logic [SRAM2_DATA_WIDTH-1:0]          sram_2_D,
    output logic                                 sram_2_GWEN,
    input  logic [SRAM2_DATA_WIDTH-1:0]          sram_2_Q
);

    localparam int PW = LEVEL_WIDTH + ENCODE_WIDTH;

    state_e                     state_q, state_d;
    logic [2:0]                 k_q, k_d;
    logic [PW-1:0]              pos_q, pos_d;
    logic [FEATURE_WIDTH-1:0]   feat_q, feat_d;
    logic                       is_add_q, is_add_d;
`ifdef UPDATER_COLLISION_CHECK_EN
    logic                       col_q, col_d;
`endif

    logic [SLOT_BITS-1:0]       slot;
    logic [SRAM2_DATA_WIDTH-1:0] feat_word;
    logic                       tag_vld, tag_eq;
    logic                       q_unused;

    assign slot     = slot_hash(pos_q);
    assign tag_vld  = sram_1_Q[VALID_BIT];
    assign tag_eq   = (sram_1_Q[PW-1:0] == pos_q);
    assign q_unused = ^{sram_1_Q[SRAM1_DATA_WIDTH-2:PW], sram_2_Q};

    updater_feat_packer #(
        .FEATURE_WIDTH (FEATURE_WIDTH),
        .WORD_WIDTH    (SRAM2_DATA_WIDTH)
    ) u_packer (
        .feature (feat_q),
        .k       (k_q),
        .word    (feat_word)
    );

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        pos_d       = pos_q;
        feat_d      = feat_q;
        is_add_d    = is_add_q;
`ifdef UPDATER_COLLISION_CHECK_EN
        col_d         = col_q;
        add_collision = 1'b0;
`endif
        add_done    = 1'b0;
        del_done    = 1'b0;
        sram_1_CEN  = 1'b1;
        sram_1_GWEN = 1'b1;
        sram_1_A    = '0;
        sram_1_D    = '0;
        sram_2_CEN  = 1'b1;
        sram_2_GWEN = 1'b1;
        sram_2_A    = '0;
        sram_2_D    = '0;

        case (state_q)
            IDLE: begin
                // Add wins a simultaneous request; the delete is simply dropped.
                if (add_anchor || del_anchor) begin
                    is_add_d = add_anchor;
                    pos_d    = pos_encode;
                    feat_d   = feature_in;
                    k_d      = '0;
`ifdef UPDATER_COLLISION_CHECK_EN
                    col_d    = 1'b0;
                    state_d  = RD_DIR;
`else
                    state_d  = add_anchor ? WR_FEAT : RD_DIR;
`endif
                end
            end
            WR_FEAT: begin
                sram_2_CEN  = 1'b0;
                sram_2_GWEN = 1'b0;
                sram_2_A    = {slot, k_q};
                sram_2_D    = feat_word;
                k_d         = k_q + 3'd1;
                if (k_q == 3'(FEAT_WORDS - 1))
                    state_d = WR_DIR;
            end
            WR_DIR: begin
                sram_1_CEN  = 1'b0;
                sram_1_GWEN = 1'b0;
                sram_1_A    = {{(SRAM1_ADDR_WIDTH-SLOT_BITS){1'b0}}, slot};
                sram_1_D    = {1'b1, {(SRAM1_DATA_WIDTH-1-PW){1'b0}}, pos_q};
                state_d     = DONE;
            end
            RD_DIR: begin
                sram_1_CEN  = 1'b0;
                sram_1_A    = {{(SRAM1_ADDR_WIDTH-SLOT_BITS){1'b0}}, slot};
                state_d     = CMP;
            end
            CMP: begin
`ifdef UPDATER_COLLISION_CHECK_EN
                if (is_add_q) begin
                    col_d   = tag_vld && !tag_eq;
                    state_d = (tag_vld && !tag_eq) ? DONE : WR_FEAT;
                end else
`endif
                state_d = (tag_vld && tag_eq) ? CLR_DIR : DONE;
            end
            CLR_DIR: begin
                sram_1_CEN  = 1'b0;
                sram_1_GWEN = 1'b0;
                sram_1_A    = {{(SRAM1_ADDR_WIDTH-SLOT_BITS){1'b0}}, slot};
                state_d     = DONE;
            end
            DONE: begin
                add_done = is_add_q;
                del_done = !is_add_q;
`ifdef UPDATER_COLLISION_CHECK_EN
                add_collision = is_add_q && col_q;
`endif
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            pos_q    <= '0;
            feat_q   <= '0;
            is_add_q <= 1'b0;
`ifdef UPDATER_COLLISION_CHECK_EN
            col_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            pos_q    <= pos_d;
            feat_q   <= feat_d;
            is_add_q <= is_add_d;
`ifdef UPDATER_COLLISION_CHECK_EN
            col_q    <= col_d;
`endif
        end
    end

endmodule

// File: tb/tb_anchor_updater.sv
// Scoreboard bench: stimulus predicts SRAM/done events from a slot dictionary,
// a negedge monitor matches every observed DUT event against them in order.
module tb_anchor_updater;

    localparam int K_WR1 = 1, K_RD1 = 2, K_WR2 = 3, K_RD2 = 4, K_ADD = 5, K_DEL = 6, K_COL = 7;

    logic         clk = 1'b0, rst = 1'b1;
    logic         add_anchor = 1'b0, del_anchor = 1'b0;
    logic         add_done, del_done;
    logic [13:0]  pos_encode = '0;
    logic [399:0] feature_in = '0;
    logic         sram_1_CEN, sram_1_GWEN, sram_2_CEN, sram_2_GWEN;
    logic [11:0]  sram_1_A, sram_2_A;
    logic [63:0]  sram_1_D, sram_2_D;
    logic [63:0]  sram_1_Q = '0;
    logic [63:0]  sram_2_Q = '0;
    logic         coll;
`ifdef UPDATER_COLLISION_CHECK_EN
    logic         add_collision;
    assign coll = add_collision;
`else
    assign coll = 1'b0;
`endif

    always #5 clk = ~clk;

    anchor_updater dut (
        .clk(clk), .rst(rst), .add_anchor(add_anchor), .del_anchor(del_anchor),
        .add_done(add_done), .del_done(del_done),
`ifdef UPDATER_COLLISION_CHECK_EN
        .add_collision(add_collision),
`endif
        .pos_encode(pos_encode), .feature_in(feature_in),
        .sram_1_CEN(sram_1_CEN), .sram_1_A(sram_1_A), .sram_1_D(sram_1_D),
        .sram_1_GWEN(sram_1_GWEN), .sram_1_Q(sram_1_Q),
        .sram_2_CEN(sram_2_CEN), .sram_2_A(sram_2_A), .sram_2_D(sram_2_D),
        .sram_2_GWEN(sram_2_GWEN), .sram_2_Q(sram_2_Q)
    );

    typedef struct {
        int          cyc;
        int          kind;
        logic [11:0] a;
        logic [63:0] d;
    } ev_t;

    ev_t  sb[$];
    int   checks = 0, errors = 0, cyc = 0;
    bit   mon_en = 1'b0;
    logic [63:0] mem1 [0:4095] = '{default: 64'h0};
    bit          ref_vld [0:511];
    logic [13:0] ref_tag [0:511];

    always @(posedge clk) cyc <= cyc + 1;

    // Directory SRAM model: one-cycle read latency.
    always @(posedge clk) begin
        if (!sram_1_CEN) begin
            if (sram_1_GWEN) sram_1_Q <= mem1[sram_1_A];
            else             mem1[sram_1_A] <= sram_1_D;
        end
    end

    always @(negedge clk) begin
        ev_t obs[$];
        ev_t e;
        obs.delete();
        if (mon_en) begin
            if (sram_1_CEN !== 1'b1)
                obs.push_back('{cyc, (sram_1_GWEN === 1'b1) ? K_RD1 : K_WR1, sram_1_A,
                                (sram_1_GWEN === 1'b1) ? 64'h0 : sram_1_D});
            else if (sram_1_GWEN !== 1'b1)
                obs.push_back('{cyc, 99, sram_1_A, sram_1_D});
            if (sram_2_CEN !== 1'b1)
                obs.push_back('{cyc, (sram_2_GWEN === 1'b1) ? K_RD2 : K_WR2, sram_2_A,
                                (sram_2_GWEN === 1'b1) ? 64'h0 : sram_2_D});
            else if (sram_2_GWEN !== 1'b1)
                obs.push_back('{cyc, 98, sram_2_A, sram_2_D});
            if (add_done !== 1'b0) obs.push_back('{cyc, (coll === 1'b1) ? K_COL : K_ADD, 12'h0, 64'h0});
            if (del_done !== 1'b0) obs.push_back('{cyc, K_DEL, 12'h0, 64'h0});
            foreach (obs[i]) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d kind=%0d a=%h d=%h, expected no event",
                             obs[i].cyc, obs[i].kind, obs[i].a, obs[i].d);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != obs[i].cyc || e.kind != obs[i].kind || e.a !== obs[i].a || e.d !== obs[i].d) begin
                        errors++;
                        $display("FAIL event got cyc=%0d kind=%0d a=%h d=%h want cyc=%0d kind=%0d a=%h d=%h",
                                 obs[i].cyc, obs[i].kind, obs[i].a, obs[i].d, e.cyc, e.kind, e.a, e.d);
                    end
                end
            end
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_event at cyc=%0d: got nothing, want kind=%0d a=%h d=%h",
                         cyc, e.kind, e.a, e.d);
            end
        end
    end

    function automatic int slot_of(input logic [13:0] p);
        return ((int'(p) % 512) ^ ((int'(p) / 512) * 16)) % 512;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, want);
        end
    endtask

    task automatic push(input int n, input int rel, input int ab, input int kind,
                        input int a, input logic [63:0] d);
        if (ab == 0 || rel <= ab) sb.push_back('{n + rel - 1, kind, 12'(a), d});
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_cen1"},  {63'h0, sram_1_CEN},  64'h1);
        chk({nm, "_gwen1"}, {63'h0, sram_1_GWEN}, 64'h1);
        chk({nm, "_cen2"},  {63'h0, sram_2_CEN},  64'h1);
        chk({nm, "_gwen2"}, {63'h0, sram_2_GWEN}, 64'h1);
        chk({nm, "_a"},     {40'h0, sram_1_A, sram_2_A}, 64'h0);
        chk({nm, "_d1"},    sram_1_D, 64'h0);
        chk({nm, "_d2"},    sram_2_D, 64'h0);
        chk({nm, "_done"},  {62'h0, add_done, del_done}, 64'h0);
    endtask

    // Issue one request; abort_at>0 applies reset during that cycle of the operation.
    task automatic do_op(input bit add, input bit del, input logic [13:0] p,
                         input logic [399:0] f, input int abort_at, input bit noise);
        int n, s, j;
        bit go;
        logic [399:0] sh;
        @(posedge clk); #1;
        add_anchor = add; del_anchor = del; pos_encode = p; feature_in = f;
        @(posedge clk); #1;
        n = cyc;
        add_anchor = noise; del_anchor = noise;
        pos_encode = 14'($urandom); feature_in = ~f;
        s = slot_of(p); j = 0; go = 1'b1;
        if (add) begin
`ifdef UPDATER_COLLISION_CHECK_EN
            push(n, 1, abort_at, K_RD1, s, 64'h0);
            j = 2;
            if (ref_vld[s] && ref_tag[s] != p) begin
                push(n, 3, abort_at, K_COL, 0, 64'h0);
                go = 1'b0;
            end
`endif
            if (go) begin
                for (int k = 0; k < 7; k++) begin
                    sh = f >> (64 * k);
                    push(n, j + 1 + k, abort_at, K_WR2, s * 8 + k, sh[63:0]);
                end
                push(n, j + 8, abort_at, K_WR1, s, (64'h1 << 63) | 64'(p));
                push(n, j + 9, abort_at, K_ADD, 0, 64'h0);
                if (abort_at == 0) begin ref_vld[s] = 1'b1; ref_tag[s] = p; end
            end
        end else if (del) begin
            push(n, 1, abort_at, K_RD1, s, 64'h0);
            if (ref_vld[s] && ref_tag[s] == p) begin
                push(n, 3, abort_at, K_WR1, s, 64'h0);
                push(n, 4, abort_at, K_DEL, 0, 64'h0);
                if (abort_at == 0) ref_vld[s] = 1'b0;
            end else begin
                push(n, 3, abort_at, K_DEL, 0, 64'h0);
            end
        end
        @(posedge clk); #1;
        add_anchor = 1'b0; del_anchor = 1'b0;
        if (abort_at > 0) begin
            while (cyc < n + abort_at - 1) begin @(posedge clk); #1; end
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            chk_idle("abort_idle");
        end
        for (int t = 0; t < 30 && sb.size() > 0; t++) @(posedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL timeout got %0d pending events, want 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
    endtask

    logic [399:0] rf;
    logic [13:0]  pool [0:3];
    logic [13:0]  rp;
    int           r;

    initial begin
        pool[0] = 14'h005; pool[1] = 14'h3E05; pool[2] = 14'h0123; pool[3] = 14'h2A7F;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        rst = 1'b0;
        mon_en = 1'b1;

        do_op(1'b1, 1'b0, 14'h005, {400{1'b1}}, 0, 1'b0);
        do_op(1'b0, 1'b1, 14'h005, '0, 0, 1'b0);
        do_op(1'b0, 1'b1, 14'h005, '0, 0, 1'b0);
        do_op(1'b1, 1'b1, 14'h3E05, {13{32'hA5C3_1E77}}, 0, 1'b0);
        do_op(1'b1, 1'b0, 14'h0777, {13{32'h1234_5678}}, 4, 1'b0);
        do_op(1'b1, 1'b0, 14'h00A, {13{32'hDEAD_BEEF}}, 0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            rf = '0;
            for (int w = 0; w < 13; w++) rf = {rf[367:0], 32'($urandom)};
            rp = pool[$urandom_range(3)] ^ (($urandom_range(1) == 1) ? 14'h210 : 14'h000);
            r  = $urandom_range(9);
            do_op(r < 4 || r > 7, r >= 4, rp, rf, 0, $urandom_range(3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/anchor_updater.md
Name: anchor_updater

Overview:
- Inserts and deletes octree anchors for the Octree accelerator.
- An anchor is identified by a 14-bit position code {level[1:0], encode[11:0]}.
- The code is hashed to a 9-bit slot. SRAM1 holds the per-slot directory entry (valid + tag); SRAM2 holds the 400-bit feature as seven 64-bit words.
- Drives two single-port SRAM macros; CEN and GWEN are active-low.

Parameters:
- FEATURE_WIDTH, 400, feature bits per anchor.
- ENCODE_WIDTH, 12, spatial code width.
- LEVEL_WIDTH, 2, octree level width (00 = level 1, 01 = level 2, 10 = level 3).
- SRAM1_ADDR_WIDTH, 12, directory SRAM address width.
- SRAM1_DATA_WIDTH, 64, directory SRAM word width.
- SRAM2_ADDR_WIDTH, 12, feature SRAM address width.
- SRAM2_DATA_WIDTH, 64, feature SRAM word width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- add_anchor  in  1  add request.
- del_anchor  in  1  delete request.
- add_done  out  1  one-cycle completion pulse for add.
- del_done  out  1  one-cycle completion pulse for delete.
- pos_encode  in  LEVEL_WIDTH+ENCODE_WIDTH  {level, encode}.
- feature_in  in  FEATURE_WIDTH  anchor feature.
- sram_1_CEN  out  1  directory chip enable, active-low.
- sram_1_A  out  SRAM1_ADDR_WIDTH  directory address.
- sram_1_D  out  SRAM1_DATA_WIDTH  directory write data.
- sram_1_GWEN  out  1  directory write enable, active-low.
- sram_1_Q  in  SRAM1_DATA_WIDTH  directory read data.
- sram_2_CEN, sram_2_A, sram_2_D, sram_2_GWEN, sram_2_Q: same roles for the feature SRAM.

Behaviour:
- Slot hash: slot[8:0] = pos[8:0] ^ {pos[13:9], 4'b0}.
- SRAM1 address = {3'b0, slot}.
- SRAM2 address = {slot, k[2:0]}, k = 0..6; word 7 of each slot is never written.
- Feature word k = feature[64k+63:64k]; word 6 = {48'b0, feature[399:384]}.
- Directory entry = {valid = bit63, 49'b0, tag[13:0] = pos}.
- States: IDLE, WR_FEAT, WR_DIR, RD_DIR, CMP, CLR_DIR, DONE.
- Request acceptance (IDLE only):
  - A request is accepted on the edge where it is sampled high; pos_encode and feature_in are latched on that edge.
  - Add has priority when both requests are high; the delete is dropped.
  - Requests arriving outside IDLE are ignored; they are not queued.
- Add sequence, cycles numbered after the accept edge:
  - Cycles 1-7: WR_FEAT writes SRAM2 words k = 0..6 (CEN=0, GWEN=0).
  - Cycle 8: WR_DIR writes the entry {1, 0, pos} to SRAM1.
  - Cycle 9: DONE, add_done = 1.
  - An existing entry in the slot is overwritten unconditionally.
- Delete sequence:
  - Cycle 1: RD_DIR issues a read (sram_1 CEN=0, GWEN=1).
  - Cycle 2: CMP; sram_1_Q is valid one cycle after the read. Match means Q[63]=1 and Q[13:0]=pos.
  - Match: cycle 3 CLR_DIR writes 64'h0, then cycle 4 DONE.
  - No match: cycle 3 DONE with no write.
  - del_done pulses for one cycle in DONE.
- DONE always returns to IDLE.
- Idle SRAM outputs: CEN=1, GWEN=1, A=0, D=0. CEN/GWEN are never low outside active write/read cycles.
- Reset: state=IDLE, add_done=0, del_done=0, all CEN/GWEN=1, A=D=0. A reset mid-operation aborts it immediately; no done pulse is issued and partial writes are not undone.

Optional Feature:
- Macro UPDATER_COLLISION_CHECK_EN.
- When defined:
  - An add_collision output (1 bit) exists.
  - Add first runs RD_DIR/CMP.
  - If Q[63]=1 and Q[13:0]≠pos, no writes occur and DONE pulses add_done together with add_collision.
  - Otherwise the normal add follows, shifted 2 cycles later (add_done in cycle 11).
- When undefined: no add_collision port; add overwrites the slot as described above.

Decomposition:
- Package updater_pkg:
  - state enum.
  - Constants FEAT_WORDS=7, SLOT_WORDS=8, SLOT_BITS=9, VALID_BIT=63.
  - Function slot_hash.
- One natural sub-module: updater_feat_packer, which slices and zero-pads feature_in into word k.

Test Plan:
- Reset: hold rst 2 cycles -> all CEN/GWEN=1, done outputs 0.
- Add pos=14'h005, feature all ones:
  - SRAM2 writes at 0x028..0x02E with D=all ones for words 0-5 and 64'h0000_0000_0000_FFFF for word 6.
  - Then SRAM1 write at A=0x005 with D=64'h8000_0000_0000_0005.
  - add_done in cycle 9.
- Delete pos=14'h005 with sram_1_Q=64'h8000_0000_0000_0005 -> read at 0x005, write 0 at 0x005, del_done in cycle 4.
- Delete pos=14'h005 with sram_1_Q=0 -> read only, no GWEN=0, del_done in cycle 3.
- add_anchor and del_anchor high together with pos=14'h3E05 -> add executes to slot 0x1F5 (SRAM2 0xFA8..0xFAE); no del_done.
- Assert rst during cycle 4 of an add -> next cycle idle outputs, no add_done; a subsequent add with pos=14'h00A completes normally to slot 0x00A.
